saph_fpu_arbiter: RTL and testbench

- Shares one pipelined FPU interface between several requesters, such as the per-attribute float incrementers and setup units in the rasterizer.
- Round-robin arbitration with single-cycle grant; downstream fixed latency is preserved exactly.
- Each requester sees an FPU with identical latency semantics, so it can run unmodified on a shared unit.
- Results are routed back to the issuing requester through a tag delay line.

---
 rtl/saph_fpu_arbiter_if.sv | 21 ++
 rtl/saph_fpu_arbiter.sv | 162 ++++++++++++++++
 tb/tb_saph_fpu_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/saph_fpu_arbiter_if.sv
// saph_fpi: FPU request/result interface shared by requesters and FPUs.
//   latency : result latency in cycles carried by this link.
//   d_trig / d_lhs / d_rhs / d_mode : operation issue (client -> FPU)
//   d_ready : issue accepted this cycle when high together with d_trig
//   q_res   : result, valid exactly latency cycles after an accepted issue
// Modports:
//   FPU : the FPU side (receives issues, returns d_ready / q_res)
//   GPU : the client side (issues operations, consumes results)
interface saph_fpi #(
  parameter int latency = 2
);
  logic        d_trig;
  logic [31:0] d_lhs;
  logic [31:0] d_rhs;
  logic [3:0]  d_mode;
  logic        d_ready;
  logic [31:0] q_res;

  modport FPU (input d_trig, d_lhs, d_rhs, d_mode, output d_ready, q_res);
  modport GPU (output d_trig, d_lhs, d_rhs, d_mode, input d_ready, q_res);
endinterface

// File: rtl/saph_fpu_arbiter.sv
// saph_fpu_arbiter: round-robin sharing of one pipelined FPU among several
// requesters. Each requester sees an FPU with the same fixed latency; results
// are routed back through a tag delay line that mirrors the FPU pipeline.
// Parameters:
//   requesters : number of requester ports (1..8)
//   latency    : FPU result latency, must match every attached interface
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req[]      : requester-facing FPU interfaces
//   fpi        : shared downstream FPU interface
//   res_valid  : one-hot, req[i].q_res carries requester i's result
//   grant_idx  : requester granted this cycle (valid when fpi.d_trig)
// Optional (macro SAPH_FPU_ARB_STATS_EN):
//   stall_cnt[]: per-requester saturating count of cycles stalled
//   accept_cnt : wrapping count of accepted issues

// Per-requester handshake gating, result steering and stall statistics.
module saph_fpu_arb_lane #(
  parameter int IW  = 1,
  parameter int IDX = 0
) (
`ifdef SAPH_FPU_ARB_STATS_EN
  input  logic          clk,
  input  logic          rst,
  input  logic          trig,
  output logic [15:0]   stall_cnt,
`endif
  input  logic [IW-1:0] win,
  input  logic          fpu_ready,
  input  logic          res_sel,
  input  logic [31:0]   res_in,
  output logic          d_ready,
  output logic [31:0]   q_res
);
  // Only the winner sees ready; everyone else retries next cycle.
  assign d_ready = (win == IW'(IDX)) && fpu_ready;
  assign q_res   = res_sel ? res_in : 32'd0;

`ifdef SAPH_FPU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (trig && !d_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

module saph_fpu_arbiter #(
  parameter int requesters = 2,
  parameter int latency    = 2,
  localparam int IW = (requesters > 1) ? $clog2(requesters) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  saph_fpi.FPU                  req [requesters],
  saph_fpi.GPU                  fpi,
  output logic [requesters-1:0] res_valid,
  output logic [IW-1:0]         grant_idx
`ifdef SAPH_FPU_ARB_STATS_EN
  ,
  output logic [requesters-1:0][15:0] stall_cnt,
  output logic [31:0]                 accept_cnt
`endif
);
  if (latency < 1) begin : g_bad_lat
    $error("saph_fpu_arbiter: latency must be >= 1");
  end
  if (fpi.latency != latency) begin : g_bad_fpi
    $error("saph_fpu_arbiter: downstream interface latency mismatch");
  end

  logic [requesters-1:0]        trig;
  logic [requesters-1:0][31:0]  lhs, rhs;
  logic [requesters-1:0][3:0]   mode;
  logic [IW-1:0]                ptr;
  logic [IW-1:0]                win;
  logic                         accept;
  logic [latency-1:0]           vld_pipe;
  logic [latency-1:0][IW-1:0]   idx_pipe;

  for (genvar g = 0; g < requesters; g++) begin : g_lane
    if (req[g].latency != latency) begin : g_bad_req
      $error("saph_fpu_arbiter: requester interface latency mismatch");
    end
    assign trig[g] = req[g].d_trig;
    assign lhs[g]  = req[g].d_lhs;
    assign rhs[g]  = req[g].d_rhs;
    assign mode[g] = req[g].d_mode;

    saph_fpu_arb_lane #(.IW(IW), .IDX(g)) u_lane (
`ifdef SAPH_FPU_ARB_STATS_EN
      .clk       (clk),
      .rst       (rst),
      .trig      (trig[g]),
      .stall_cnt (stall_cnt[g]),
`endif
      .win       (win),
      .fpu_ready (fpi.d_ready),
      .res_sel   (res_valid[g]),
      .res_in    (fpi.q_res),
      .d_ready   (req[g].d_ready),
      .q_res     (req[g].q_res)
    );
  end

  // Rotating priority search from ptr; falls back to ptr with no trig so
  // the operand muxes stay deterministic.
  always_comb begin
    int  j;
    logic found;
    win   = ptr;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < requesters; k++) begin
      j = int'(ptr) + k;
      if (j >= requesters) j = j - requesters;
      if (!found && trig[j]) begin
        win   = IW'(j);
        found = 1'b1;
      end
    end
  end

  assign grant_idx  = win;
  assign fpi.d_trig = |trig;
  assign fpi.d_lhs  = lhs[win];
  assign fpi.d_rhs  = rhs[win];
  assign fpi.d_mode = mode[win];
  assign accept     = fpi.d_trig && fpi.d_ready;

  // Tag line shifts every cycle so it stays aligned with the FPU pipeline;
  // reset drops in-flight tags, so late FPU results are never delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      idx_pipe[0] <= win;
      for (int s = 1; s < latency; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        idx_pipe[s] <= idx_pipe[s-1];
      end
      if (accept)
        ptr <= (int'(win) == requesters - 1) ? '0 : win + 1'b1;
    end
  end

  always_comb begin
    res_valid = '0;
    if (vld_pipe[latency-1]) res_valid[idx_pipe[latency-1]] = 1'b1;
  end

`ifdef SAPH_FPU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)         accept_cnt <= '0;
    else if (accept) accept_cnt <= accept_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_saph_fpu_arbiter.sv
// Bench for saph_fpu_arbiter: a 2-requester and a 3-requester instance, each
// behind a latency-2 FPU model. A scoreboard queues expected results at issue
// time and compares them when due; a vector table checks grant/ready.
module tb_saph_fpu_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic frdy;

  saph_fpi #(.latency(LAT)) rqa [2] ();
  saph_fpi #(.latency(LAT)) fa ();
  saph_fpi #(.latency(LAT)) rqb [3] ();
  saph_fpi #(.latency(LAT)) fb ();

  logic [1:0]       a_trig, a_rdy, a_resv;
  logic [1:0][31:0] a_lhs, a_rhs, a_q;
  logic [1:0][3:0]  a_mode;
  logic             a_gidx;
  logic [2:0]       b_trig, b_rdy, b_resv;
  logic [2:0][31:0] b_lhs, b_rhs, b_q;
  logic [2:0][3:0]  b_mode;
  logic [1:0]       b_gidx;
`ifdef SAPH_FPU_ARB_STATS_EN
  logic [1:0][15:0] a_stall;
  logic [2:0][15:0] b_stall;
  logic [31:0]      a_acc, b_acc;
`endif

  for (genvar g = 0; g < 2; g++) begin : g_a
    assign rqa[g].d_trig = a_trig[g];
    assign rqa[g].d_lhs  = a_lhs[g];
    assign rqa[g].d_rhs  = a_rhs[g];
    assign rqa[g].d_mode = a_mode[g];
    assign a_rdy[g]      = rqa[g].d_ready;
    assign a_q[g]        = rqa[g].q_res;
  end
  for (genvar g = 0; g < 3; g++) begin : g_b
    assign rqb[g].d_trig = b_trig[g];
    assign rqb[g].d_lhs  = b_lhs[g];
    assign rqb[g].d_rhs  = b_rhs[g];
    assign rqb[g].d_mode = b_mode[g];
    assign b_rdy[g]      = rqb[g].d_ready;
    assign b_q[g]        = rqb[g].q_res;
  end

  // Single precision <-> real for normal numbers; enough for the add model.
  function automatic real s2r(input logic [31:0] f);
    if (f[30:0] == 31'd0) return 0.0;
    return $bitstoreal({f[31], {3'b0, f[30:23]} + 11'd896, f[22:0], 29'b0});
  endfunction
  function automatic logic [31:0] r2s(input real x);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(x);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction
  // mode 0: float add, otherwise integer add
  function automatic logic [31:0] fpu_op(input logic [31:0] l, input logic [31:0] r,
                                         input logic [3:0] m);
    if (m == 4'd0) return r2s(s2r(l) + s2r(r));
    return l + r;
  endfunction

  // Latency-2 FPU models; idle slots carry junk so leaks are visible.
  logic [31:0] fa_p0 = '0, fa_p1 = '0, fb_p0 = '0, fb_p1 = '0;
  assign fa.d_ready = frdy;
  assign fa.q_res   = fa_p1;
  assign fb.d_ready = frdy;
  assign fb.q_res   = fb_p1;
  always @(posedge clk) begin
    fa_p0 <= (fa.d_trig && fa.d_ready) ? fpu_op(fa.d_lhs, fa.d_rhs, fa.d_mode) : 32'hDEAD0000;
    fa_p1 <= fa_p0;
    fb_p0 <= (fb.d_trig && fb.d_ready) ? fpu_op(fb.d_lhs, fb.d_rhs, fb.d_mode) : 32'hDEAD0001;
    fb_p1 <= fb_p0;
  end

  saph_fpu_arbiter #(.requesters(2), .latency(LAT)) u_a (
    .clk(clk), .rst(rst), .req(rqa), .fpi(fa), .res_valid(a_resv), .grant_idx(a_gidx)
`ifdef SAPH_FPU_ARB_STATS_EN
    , .stall_cnt(a_stall), .accept_cnt(a_acc)
`endif
  );
  saph_fpu_arbiter #(.requesters(3), .latency(LAT)) u_b (
    .clk(clk), .rst(rst), .req(rqb), .fpi(fb), .res_valid(b_resv), .grant_idx(b_gidx)
`ifdef SAPH_FPU_ARB_STATS_EN
    , .stall_cnt(b_stall), .accept_cnt(b_acc)
`endif
  );

  typedef struct { int due; int idx; logic [31:0] res; } sb_t;
  sb_t qa[$];
  sb_t qb[$];
  int  cyc, pa, pb;
  int  checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic int win_of(input logic [7:0] t, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      int j = (p + k) % n;
      if (t[j]) return j;
    end
    return p;
  endfunction

  // One cycle: drive at negedge, check at negedge+1, update the model.
  task automatic step(input logic [1:0] ta, input logic [2:0] tb, input logic fr,
                      input logic r, input bit rnd);
    int wa, wb;
    logic [1:0] eva;
    logic [2:0] evb;
    logic [1:0][31:0] eqa;
    logic [2:0][31:0] eqb;
    sb_t e;
    @(negedge clk);
    rst = r; frdy = fr; a_trig = ta; b_trig = tb;
    if (rnd) begin
      for (int i = 0; i < 2; i++) begin a_lhs[i] = $urandom; a_rhs[i] = $urandom; a_mode[i] = 4'd1; end
      for (int i = 0; i < 3; i++) begin b_lhs[i] = $urandom; b_rhs[i] = $urandom; b_mode[i] = 4'd1; end
    end
    #1;
    wa = win_of({6'b0, ta}, pa, 2);
    wb = win_of({5'b0, tb}, pb, 3);
    chk("a_gidx", 32'(a_gidx), wa);
    chk("a_dtrig", 32'(fa.d_trig), 32'(|ta));
    chk("a_dlhs", fa.d_lhs, a_lhs[wa]);
    chk("a_drdy", 32'(a_rdy), 32'((2'b01 << wa) & {2{fr}}));
    chk("b_gidx", 32'(b_gidx), wb);
    chk("b_dtrig", 32'(fb.d_trig), 32'(|tb));
    chk("b_drdy", 32'(b_rdy), 32'((3'b001 << wb) & {3{fr}}));
    eva = '0; eqa = '0; evb = '0; eqb = '0;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      e = qa.pop_front(); eva[e.idx] = 1'b1; eqa[e.idx] = e.res;
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      e = qb.pop_front(); evb[e.idx] = 1'b1; eqb[e.idx] = e.res;
    end
    chk("a_resv", 32'(a_resv), 32'(eva));
    for (int i = 0; i < 2; i++) chk("a_qres", a_q[i], eqa[i]);
    chk("b_resv", 32'(b_resv), 32'(evb));
    for (int i = 0; i < 3; i++) chk("b_qres", b_q[i], eqb[i]);
    if (r) begin
      qa.delete(); qb.delete(); pa = 0; pb = 0;
    end else begin
      if (|ta && fr) begin
        qa.push_back('{cyc + LAT, wa, fpu_op(a_lhs[wa], a_rhs[wa], a_mode[wa])});
        pa = (wa + 1) % 2;
      end
      if (|tb && fr) begin
        qb.push_back('{cyc + LAT, wb, fpu_op(b_lhs[wb], b_rhs[wb], b_mode[wb])});
        pb = (wb + 1) % 3;
      end
    end
    cyc++;
  endtask

  typedef struct { logic [1:0] trig; logic frdy; logic rst; int gidx; logic [1:0] rdy; } vec_t;
  vec_t tbl[13];

  initial begin
    tbl[0]  = '{2'b11, 1'b1, 1'b0, 0, 2'b01};
    tbl[1]  = '{2'b11, 1'b1, 1'b0, 1, 2'b10};
    tbl[2]  = '{2'b10, 1'b1, 1'b0, 1, 2'b10};
    tbl[3]  = '{2'b01, 1'b0, 1'b0, 0, 2'b00};
    tbl[4]  = '{2'b11, 1'b0, 1'b0, 0, 2'b00};
    tbl[5]  = '{2'b10, 1'b1, 1'b0, 1, 2'b10};
    tbl[6]  = '{2'b00, 1'b1, 1'b0, 0, 2'b01};
    tbl[7]  = '{2'b01, 1'b1, 1'b0, 0, 2'b01};
    tbl[8]  = '{2'b00, 1'b1, 1'b0, 1, 2'b10};
    tbl[9]  = '{2'b11, 1'b1, 1'b1, 1, 2'b10};
    tbl[10] = '{2'b11, 1'b1, 1'b0, 0, 2'b01};
    tbl[11] = '{2'b10, 1'b0, 1'b0, 1, 2'b00};
    tbl[12] = '{2'b10, 1'b1, 1'b0, 1, 2'b10};

    rst = 1'b1; frdy = 1'b1; a_trig = '0; b_trig = '0;
    a_lhs = '0; a_rhs = '0; a_mode = '0; b_lhs = '0; b_rhs = '0; b_mode = '0;
    cyc = 0; pa = 0; pb = 0;
    repeat (2) @(posedge clk);

    // reset state
    step(2'b00, 3'b000, 1'b1, 1'b1, 1'b1);
    step(2'b00, 3'b000, 1'b1, 1'b1, 1'b1);

    // req0 alone: 1.0 + 2.0
    a_lhs[0] = 32'h3F800000; a_rhs[0] = 32'h40000000; a_mode[0] = 4'd0;
    step(2'b01, 3'b000, 1'b1, 1'b0, 1'b0);
    step(2'b00, 3'b000, 1'b1, 1'b0, 1'b1);
    step(2'b00, 3'b000, 1'b1, 1'b0, 1'b1);
    chk("t1_resv", 32'(a_resv), 32'h1);
    chk("t1_q0", a_q[0], 32'h40400000);
    chk("t1_q1", a_q[1], 32'h0);

    // continuous contention from ptr=0
    step(2'b00, 3'b000, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(2'b11, 3'b000, 1'b1, 1'b0, 1'b1);
      chk("t2_gidx", 32'(a_gidx), k % 2);
      if (k >= 2) chk("t2_resv", 32'(a_resv), (k % 2 == 0) ? 32'h1 : 32'h2);
    end
    repeat (2) step(2'b00, 3'b000, 1'b1, 1'b0, 1'b1);

    // FPU stall with ptr=1
    step(2'b01, 3'b000, 1'b1, 1'b0, 1'b1);
    repeat (3) begin
      step(2'b10, 3'b000, 1'b0, 1'b0, 1'b1);
      chk("t3_stall_gidx", 32'(a_gidx), 32'h1);
    end
    step(2'b10, 3'b000, 1'b1, 1'b0, 1'b1);
    repeat (2) step(2'b00, 3'b000, 1'b1, 1'b0, 1'b1);

    // reset one cycle after accept discards the tag
    step(2'b01, 3'b000, 1'b1, 1'b0, 1'b1);
    step(2'b00, 3'b000, 1'b1, 1'b1, 1'b1);
    step(2'b00, 3'b000, 1'b1, 1'b0, 1'b1);
    chk("t4_resv", 32'(a_resv), 32'h0);
    chk("t4_ptr", 32'(a_gidx), 32'h0);

    // three requesters, only req2 triggers
    for (int k = 0; k < 6; k++) begin
      step(2'b00, 3'b100, 1'b1, 1'b0, 1'b1);
      chk("t5_gidx", 32'(b_gidx), 32'h2);
      if (k >= LAT) chk("t5_resv", 32'(b_resv), 32'h4);
    end
    step(2'b00, 3'b000, 1'b1, 1'b0, 1'b1);
    chk("t5_ptr", 32'(b_gidx), 32'h0);
    step(2'b00, 3'b000, 1'b1, 1'b0, 1'b1);

    // vector table from ptr=0
    step(2'b00, 3'b000, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].trig, 3'b000, tbl[i].frdy, tbl[i].rst, 1'b1);
      chk("tbl_gidx", 32'(a_gidx), tbl[i].gidx);
      chk("tbl_rdy", 32'(a_rdy), 32'(tbl[i].rdy));
    end
    repeat (2) step(2'b00, 3'b000, 1'b1, 1'b0, 1'b1);

`ifdef SAPH_FPU_ARB_STATS_EN
    step(2'b00, 3'b000, 1'b1, 1'b1, 1'b1);
    repeat (10) step(2'b11, 3'b000, 1'b1, 1'b0, 1'b1);
    step(2'b00, 3'b000, 1'b1, 1'b0, 1'b1);
    chk("st_stall0", 32'(a_stall[0]), 32'd5);
    chk("st_stall1", 32'(a_stall[1]), 32'd5);
    chk("st_acc", a_acc, 32'd10);
    @(negedge clk);
    a_trig = 2'b01; frdy = 1'b0;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    chk("st_sat0", 32'(a_stall[0]), 32'hFFFF);
    chk("st_hold1", 32'(a_stall[1]), 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
